// File: rtl/pool2x2_downsampler.sv
// pool2x2_downsampler: streaming 2x2 floor-average pooling of a raster-order frame.
// Horizontal pairs are summed into h_acc. Even rows park their pair sums in a
// half-row line buffer. Odd rows combine those sums and emit one pooled pixel
// per 2x2 block through a single output register.
//
// Handshake (both sides): a beat moves on a rising edge where valid & ready are
// both high. A source holds its data and valid stable until that beat completes.
// in_ready is combinational. Input is accepted whenever the output register is
// empty or is draining this cycle.
module pool2x2_downsampler #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int PW   = PIXEL_BIT_WIDTH;
    localparam int XW   = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int YW   = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int HALF = IN_COLS / 2;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PW:0]   h_acc;
    logic [PW:0]   linebuf [HALF];

    logic          accept;
    logic          x_last;
    logic          y_last;
    logic          produce;
    logic [IW-1:0] lb_idx;
    logic [PW:0]   pair_sum;
    logic [PW+1:0] sum4;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign x_last   = (x == XW'(IN_COLS - 1));
    assign y_last   = (y == YW'(IN_ROWS - 1));
    // Frame dimensions are even, so the counter LSB gives column/row parity.
    assign produce  = accept & x[0] & y[0];
    assign lb_idx   = IW'(x >> 1);
    assign pair_sum = h_acc + {1'b0, pixel_in};
    assign sum4     = {1'b0, linebuf[lb_idx]} + {1'b0, pair_sum};

    // Raster position counters and left-pixel holding register; they move only on accepts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            h_acc <= '0;
        end else if (accept) begin
            if (!x[0]) begin
                h_acc <= {1'b0, pixel_in};
            end
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Line buffer of even-row pair sums; every entry is written before it is read in a frame.
    always_ff @(posedge clk) begin
        if (accept && x[0] && !y[0]) begin
            linebuf[lb_idx] <= pair_sum;
        end
    end

    // Output register: load a new result, else clear once the held result is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_out <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (produce) begin
            pixel_out <= PW'(sum4 >> 2);
            out_valid <= 1'b1;
            out_last  <= x_last & y_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2x2_downsampler.sv
// tb_pool2x2_downsampler: directed scenarios on a 4x4 frame with an expected-output queue.
module tb_pool2x2_downsampler;

    localparam int PW = 12;
    localparam int R  = 4;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pixel_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;

    int errors = 0;
    int checks = 0;
    logic [PW:0]   exp_q[$];
    logic [PW-1:0] frame_px [R*C];

    pool2x2_downsampler #(
        .PIXEL_BIT_WIDTH(PW),
        .IN_ROWS(R),
        .IN_COLS(C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pixel_in(pixel_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pixel_out(pixel_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model: floor-average of each 2x2 block, last flag on the final block.
    task automatic push_expect();
        int s;
        logic [PW:0] e;
        for (int by = 0; by < R / 2; by++) begin
            for (int bx = 0; bx < C / 2; bx++) begin
                s = int'(frame_px[(2*by)*C + 2*bx]) + int'(frame_px[(2*by)*C + 2*bx + 1])
                  + int'(frame_px[(2*by+1)*C + 2*bx]) + int'(frame_px[(2*by+1)*C + 2*bx + 1]);
                e[PW-1:0] = PW'(s / 4);
                e[PW]     = (by == R / 2 - 1) && (bx == C / 2 - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill(input logic [PW-1:0] v);
        for (int i = 0; i < R * C; i++) frame_px[i] = v;
    endtask

    // Drive one pixel and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic send_pixel(input logic [PW-1:0] v);
        int guard;
        logic acc;
        guard    = 0;
        acc      = 1'b0;
        pixel_in = v;
        in_valid = 1'b1;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 32'(acc), 1);
    endtask

    task automatic send_frame(input bit bubbles, input bit lat_chk);
        int n;
        push_expect();
        for (int k = 0; k < R * C; k++) begin
            if (bubbles) begin
                in_valid = 1'b0;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_pixel(frame_px[k]);
            if (lat_chk)
                check("latency_out_valid", 32'(out_valid),
                      32'((k + 1 == 6) || (k + 1 == 8) || (k + 1 == 14) || (k + 1 == 16)));
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 0);
    endtask

    // Scoreboard: compare each output beat that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 0);
            end else begin
                logic [PW:0] e;
                e = exp_q.pop_front();
                check("pixel_out", 32'(pixel_out), 32'(e[PW-1:0]));
                check("out_last", 32'(out_last), 32'(e[PW]));
            end
        end
    end

    initial begin
        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_pixel_out", 32'(pixel_out), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Uniform frame with latency checks
        fill(12'd100);
        send_frame(1'b0, 1'b1);
        wait_drain();

        // Rounding: top-left block sums to 10, floor gives 2
        fill(12'd0);
        frame_px[0] = 12'd1;
        frame_px[1] = 12'd2;
        frame_px[4] = 12'd3;
        frame_px[5] = 12'd4;
        send_frame(1'b0, 1'b0);
        wait_drain();

        // Full scale
        fill(12'd4095);
        send_frame(1'b0, 1'b0);
        wait_drain();

        // Backpressure on the first output
        fill(12'd100);
        push_expect();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send_pixel(frame_px[k]);
        in_valid = 1'b0;
        check("bp_first_valid", 32'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_hold_pixel", 32'(pixel_out), 100);
            check("bp_hold_last", 32'(out_last), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 6; k < R * C; k++) send_pixel(frame_px[k]);
        wait_drain();

        // Bubbles
        fill(12'd100);
        send_frame(1'b1, 1'b0);
        wait_drain();

        // Reset mid-frame
        fill(12'd100);
        for (int k = 0; k < 6; k++) send_pixel(frame_px[k]);
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 1);
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_last", 32'(out_last), 0);
        check("async_rst_pixel", 32'(pixel_out), 0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Back-to-back frames after reset
        fill(12'd8);
        send_frame(1'b0, 1'b0);
        fill(12'd16);
        send_frame(1'b0, 1'b0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
